// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants and FSM state type for the OCI DCT trace packer.
package nios2_oci_dct_pkg;

  localparam int ATOM_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = ATOM_W * SLOTS;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_FLUSH,
    ST_END_FLUSH,
    ST_END_DRAIN,
    ST_DONE
  } dct_state_t;

endpackage

// File: rtl/nios2_oci_dct_outreg.sv
// Single-entry valid/ready holding register for packed DCT words.
module nios2_oci_dct_outreg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         out_free
);

  assign out_free = !valid || ready;

  // The word is only replaced on load; it stays put while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot DCT words and drains them on end of test.
//
// state        | meaning
// ST_RUN       | accepting atoms, full words go out automatically
// ST_FLUSH     | pushing the partial word out, then back to RUN
// ST_END_FLUSH | test ending: pushing the last partial word out
// ST_END_DRAIN | waiting for the consumer to take the last word
// ST_DONE      | drained; test_has_ended high until reset
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic             atom_ready,
  input  logic             flush,
  input  logic             test_ending,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             dct_valid,
  input  logic             dct_ready,
  output logic             test_has_ended
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

  dct_state_t       state, state_nxt;
  logic [BUF_W-1:0] acc_buf, acc_buf_wr;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept, xfer, out_free, flushing;

  assign flushing   = (state == ST_FLUSH) || (state == ST_END_FLUSH);
  assign atom_ready = (state == ST_RUN) && (acc_cnt != FULL_CNT);
  assign accept     = atom_valid && atom_ready;
  assign xfer       = out_free && ((acc_cnt == FULL_CNT) || (flushing && acc_cnt != '0));
  assign test_has_ended = (state == ST_DONE);

  always_comb begin
    acc_buf_wr = acc_buf;
    for (int i = 0; i < SLOTS; i++) begin
      if (acc_cnt == CNT_W'(i)) acc_buf_wr[i*ATOM_W +: ATOM_W] = atom_data;
    end
  end

  // accept and xfer never coincide: accept needs a non-full RUN accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_buf <= '0;
      acc_cnt <= '0;
    end else if (xfer) begin
      acc_buf <= '0;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_buf <= acc_buf_wr;
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN: begin
        if (test_ending) state_nxt = ST_END_FLUSH;
        else if (flush)  state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (test_ending)                 state_nxt = ST_END_FLUSH;
        else if (acc_cnt == '0 || xfer)  state_nxt = ST_RUN;
      end
      ST_END_FLUSH: begin
        if (acc_cnt == '0 || xfer) state_nxt = ST_END_DRAIN;
      end
      ST_END_DRAIN: begin
        if (!dct_valid || dct_ready) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_RUN;
    endcase
  end

  nios2_oci_dct_outreg #(.W(BUF_W + CNT_W)) u_outreg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (xfer),
    .din      ({acc_cnt, acc_buf}),
    .ready    (dct_ready),
    .dout     ({dct_count, dct_buffer}),
    .valid    (dct_valid),
    .out_free (out_free)
  );

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Randomised and directed bench for the DCT packer against a queue-based atom/word model.
module tb_nios2_oci_dct_packer;
  import nios2_oci_dct_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              atom_valid = 1'b0;
  logic [ATOM_W-1:0] atom_data = '0;
  logic              atom_ready;
  logic              flush = 1'b0;
  logic              test_ending = 1'b0;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              dct_valid;
  logic              dct_ready = 1'b0;
  logic              test_has_ended;

  always #5 clk = ~clk;

  nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_has_ended (test_has_ended)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  mq[$];      // atoms accepted but not yet packed
  logic [33:0] expq[$];    // {count, buffer} words still owed to the consumer
  bit          model_run = 1'b1;
  bit          prev_hold = 1'b0;
  logic [33:0] held;
  logic        last_v, last_ar;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic finalize();
    logic [29:0] b;
    b = '0;
    if (mq.size() != 0) begin
      for (int i = 0; i < mq.size(); i++) b[2*i +: 2] = mq[i];
      expq.push_back({4'(mq.size()), b});
      mq.delete();
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs, checks, updates model.
  task automatic step(input logic v, input logic [1:0] d, input logic fl,
                      input logic te, input logic rdy);
    logic        ar;
    logic [33:0] w, e;
    ar = atom_ready;
    atom_valid = v; atom_data = d; flush = fl && ar; test_ending = te; dct_ready = rdy;
    #1;
    w = {dct_count, dct_buffer};
    last_v = dct_valid;
    last_ar = ar;
    if (prev_hold) begin
      chk("hold_valid", 64'(dct_valid), 64'd1);
      chk("hold_word", 64'(w), 64'(held));
    end
    if (dct_valid && rdy) begin
      if (expq.size() == 0) chk("unexpected_word", 64'(expq.size()), 64'd1);
      else begin
        e = expq.pop_front();
        chk("word", 64'(w), 64'(e));
      end
    end
    prev_hold = dct_valid && !rdy;
    held = w;
    if (v && ar) begin
      mq.push_back(d);
      if (mq.size() == SLOTS) finalize();
    end
    if (fl && ar && model_run) finalize();
    if (te && model_run) begin
      finalize();
      model_run = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    atom_valid = 1'b0; flush = 1'b0; test_ending = 1'b0; dct_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(dct_valid), 64'd0);
    chk("rst_count", 64'(dct_count), 64'd0);
    chk("rst_buffer", 64'(dct_buffer), 64'd0);
    chk("rst_ended", 64'(test_has_ended), 64'd0);
    chk("rst_atom_ready", 64'(atom_ready), 64'd1);
    mq.delete(); expq.delete();
    model_run = 1'b1; prev_hold = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Full word, slot i = i mod 4; check latency and single-cycle valid.
    for (int i = 0; i < 15; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("lat_valid_low", 64'(last_v), 64'd0);
    chk("full_ready_gap", 64'(last_ar), 64'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("lat_valid_high", 64'(last_v), 64'd1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("valid_one_cycle", 64'(last_v), 64'd0);

    // Partial word 3,2,1 via flush.
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("flush_valid", 64'(last_v), 64'd1);
    chk("flush_back_run", 64'(last_ar), 64'd1);
    idle(2, 1'b1);
    chk("flush_drained", 64'(expq.size()), 64'd0);

    // Backpressure: consumer stalls for 40 cycles under continuous atoms.
    for (int i = 0; i < 40; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_stalled", 64'(last_ar), 64'd0);
    chk("bp_words_pending", 64'(expq.size()), 64'd2);
    idle(20, 1'b1);
    chk("bp_drained", 64'(expq.size()), 64'd0);

    // Random traffic with flushes and consumer stalls.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom % 4 != 0), 2'($urandom), 1'($urandom % 25 == 0), 1'b0,
           1'($urandom % 3 != 0));
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    idle(20, 1'b1);
    chk("rand_drained", 64'(expq.size() + mq.size()), 64'd0);

    // Reset with a held word and 7 atoms buffered.
    for (int k = 0; k < 40 && !(expq.size() == 1 && mq.size() == 7); k++)
      step(1'b1, 2'($urandom), 1'b0, 1'b0, 1'b0);
    chk("pre_reset_acc", 64'(mq.size()), 64'd7);
    chk("pre_reset_valid", 64'(dct_valid), 64'd1);
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("post_reset_drained", 64'(expq.size()), 64'd0);

    // End of test with 5 atoms buffered.
    for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20 && !test_has_ended; k++) step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    chk("end_ended", 64'(test_has_ended), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'($urandom), 1'b0, 1'b1, 1'b1);
      chk("end_sticky", 64'(test_has_ended), 64'd1);
      chk("end_no_accept", 64'(last_ar), 64'd0);
    end
    chk("end_drained", 64'(expq.size() + mq.size()), 64'd0);

    // flush and test_ending on the 15th atom: one full word, then DONE.
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'($urandom), 1'b1, 1'b1, 1'b1);
    chk("combo_one_word", 64'(expq.size()), 64'd1);
    for (int k = 0; k < 20 && !test_has_ended; k++) step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    chk("combo_ended", 64'(test_has_ended), 64'd1);
    idle(3, 1'b1);
    chk("combo_drained", 64'(expq.size() + mq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
